// File: rtl/csi2_pkg.sv
// Shared types and constants for the CSI-2 packet parser.
//   - csi2_state_e : parser FSM states
//   - csi2_hdr_t   : packet header word as mapped by the PHY {ECC, WC, VC, DT}
//   - csi2_out_t   : registered output bundle of the parser
//   - ECC_MASK     : Hamming parity masks over the 24 header data bits
//   - ecc_flip_mask: syndrome -> single data-bit correction mask
//   - crc16_byte   : one-byte step of the reflected CRC-16 (0x8408)
package csi2_pkg;

  localparam logic [5:0]  SHORT_DT_MAX = 6'h0F;
  localparam logic [15:0] CRC16_POLY   = 16'h8408;
  localparam logic [15:0] CRC16_SEED   = 16'hFFFF;

  // Index k holds the data bits covered by parity bit P[k].
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00,  // P5
    24'hDF03F0,  // P4
    24'hB8E38E,  // P3
    24'h749A6D,  // P2
    24'hF2555B,  // P1
    24'hF12CB7   // P0
  };

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StHoldoff
  } csi2_state_e;

  typedef struct packed {
    logic [7:0]  ecc;
    logic [15:0] wc;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } csi2_hdr_t;

  typedef struct packed {
    logic        hdr_valid;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [31:0] data;
    logic [3:0]  be;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ecc_corr;
    logic        ecc_err;
    logic        trunc_err;
    logic        phy_rst;
  } csi2_out_t;

  // Returns a one-hot mask of the data bit whose parity column equals syn, else zero.
  function automatic logic [23:0] ecc_flip_mask(input logic [5:0] syn);
    logic [23:0] m;
    logic [5:0]  col;
    m = '0;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 6; k++) col[k] = ECC_MASK[k][i];
      if (col == syn) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/csi2_pkt_parser_if.sv
// Bus bundle between the D-PHY word stream, the packet parser and its consumer.
//   data_i/valid_i      : mapped 32-bit PHY word and its valid (no backpressure)
//   hdr_*_o             : decoded header strobe and fields
//   pkt_*_o             : framed payload words with byte enables
//   ecc_corr_o/ecc_err_o/trunc_err_o : status strobes
//   phy_rst_o           : end-of-packet pulse back to the PHY
//   crc_err_o           : payload CRC mismatch strobe (only with CSI2_CRC_CHECK_EN)
// modport master: stimulus/PHY side; modport slave: the parser.
interface csi2_pkt_parser_if;
  logic [31:0] data_i;
  logic        valid_i;
  logic        hdr_valid_o;
  logic [1:0]  hdr_vc_o;
  logic [5:0]  hdr_dt_o;
  logic [15:0] hdr_wc_o;
  logic [31:0] pkt_data_o;
  logic [3:0]  pkt_be_o;
  logic        pkt_valid_o;
  logic        pkt_sop_o;
  logic        pkt_eop_o;
  logic        ecc_corr_o;
  logic        ecc_err_o;
  logic        trunc_err_o;
  logic        phy_rst_o;
`ifdef CSI2_CRC_CHECK_EN
  logic        crc_err_o;
`endif

  modport master (
    output data_i, valid_i,
    input  hdr_valid_o, hdr_vc_o, hdr_dt_o, hdr_wc_o, pkt_data_o, pkt_be_o, pkt_valid_o,
    input  pkt_sop_o, pkt_eop_o, ecc_corr_o, ecc_err_o, trunc_err_o, phy_rst_o
`ifdef CSI2_CRC_CHECK_EN
    , input crc_err_o
`endif
  );

  modport slave (
    input  data_i, valid_i,
    output hdr_valid_o, hdr_vc_o, hdr_dt_o, hdr_wc_o, pkt_data_o, pkt_be_o, pkt_valid_o,
    output pkt_sop_o, pkt_eop_o, ecc_corr_o, ecc_err_o, trunc_err_o, phy_rst_o
`ifdef CSI2_CRC_CHECK_EN
    , output crc_err_o
`endif
  );
endinterface

// File: rtl/csi2_hdr_ecc.sv
// Combinational CSI-2 header Hamming check/correct.
//   hdr_i  : raw header word (ECC[7:6] ignored)
//   hdr_o  : header with a single flipped data bit repaired
//   corr_o : single-bit error found (in data or in the ECC byte itself)
//   err_o  : uncorrectable header
module csi2_hdr_ecc
  import csi2_pkg::*;
(
  input  csi2_hdr_t hdr_i,
  output csi2_hdr_t hdr_o,
  output logic      corr_o,
  output logic      err_o
);

  logic [23:0] w_data;
  logic [23:0] w_flip;
  logic [5:0]  w_calc;
  logic [5:0]  w_syn;
  logic        w_unused_ecc_hi;

  assign w_unused_ecc_hi = ^hdr_i.ecc[7:6];

  always_comb begin
    w_data = {hdr_i.wc, hdr_i.vc, hdr_i.dt};
    w_calc = '0;
    for (int k = 0; k < 6; k++) w_calc[k] = ^(w_data & ECC_MASK[k]);
    w_syn  = w_calc ^ hdr_i.ecc[5:0];
    w_flip = ecc_flip_mask(w_syn);
    // A one-hot syndrome is an error in the ECC byte: data is already good.
    corr_o = (w_syn != 6'd0) && ((w_flip != 24'd0) || $onehot(w_syn));
    err_o  = (w_syn != 6'd0) && !corr_o;
    hdr_o  = hdr_i;
    {hdr_o.wc, hdr_o.vc, hdr_o.dt} = w_data ^ w_flip;
  end

endmodule

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser on the D-PHY byte clock. Decodes/corrects the header, strips the
// payload into byte-enabled words, drops the CRC and pulses phy_rst_o at end of packet.
//   clk_i, rst_i : byte clock, asynchronous active-high reset
//   bus (slave)  : word input, header/payload outputs and status strobes
// Optional: define CSI2_CRC_CHECK_EN to add payload CRC-16 checking and bus.crc_err_o.
// Parameters: GAP_TIMEOUT idle cycles before a long packet aborts, HOLDOFF cycles of
// ignored input after each phy_rst_o.
module csi2_pkt_parser
  import csi2_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 16,
  parameter int unsigned HOLDOFF     = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  csi2_pkt_parser_if.slave bus
);

  localparam int unsigned     GapW     = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam int unsigned     HoldW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_TIMEOUT - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);

  csi2_state_e      r_state, w_state;
  logic [16:0]      r_rem, w_rem;           // bytes left including CRC
  logic [15:0]      r_pay_left, w_pay_left; // payload bytes left
  logic             r_sop_pend, w_sop_pend;
  logic [GapW-1:0]  r_gap, w_gap;
  logic [HoldW-1:0] r_hold, w_hold;
  csi2_out_t        r_out, w_out;

  csi2_hdr_t   w_hdr;
  logic        w_ecc_corr, w_ecc_err, w_unused_hdr_ecc;
  logic [2:0]  w_take, w_npay;
  logic [16:0] w_rem_nxt;
  logic [15:0] w_pay_nxt;
  logic [3:0]  w_be;

  csi2_hdr_ecc u_hdr_ecc (
    .hdr_i  (csi2_hdr_t'(bus.data_i)),
    .hdr_o  (w_hdr),
    .corr_o (w_ecc_corr),
    .err_o  (w_ecc_err)
  );

  assign w_unused_hdr_ecc = ^w_hdr.ecc;

  always_comb begin
    w_take    = (r_rem >= 17'd4) ? 3'd4 : r_rem[2:0];
    w_npay    = (r_pay_left >= {13'd0, w_take}) ? w_take : r_pay_left[2:0];
    w_rem_nxt = r_rem - {14'd0, w_take};
    w_pay_nxt = r_pay_left - {13'd0, w_npay};
    case (w_npay)
      3'd0:    w_be = 4'b0000;
      3'd1:    w_be = 4'b0001;
      3'd2:    w_be = 4'b0011;
      3'd3:    w_be = 4'b0111;
      default: w_be = 4'b1111;
    endcase
  end

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] r_crc, w_crc, w_crc_step;
  logic [15:0] r_crc_rx, w_crc_rx, w_crc_rx_step;
  logic        r_crc_err, w_crc_err;

  // Byte j of the current word has (r_rem - j) bytes left: 2 = CRC LSB, 1 = CRC MSB.
  always_comb begin
    w_crc_step    = r_crc;
    w_crc_rx_step = r_crc_rx;
    for (int j = 0; j < 4; j++) begin
      if (w_be[j]) w_crc_step = crc16_byte(w_crc_step, bus.data_i[8*j +: 8]);
      if (r_rem == 17'(j) + 17'd2) w_crc_rx_step[7:0]  = bus.data_i[8*j +: 8];
      if (r_rem == 17'(j) + 17'd1) w_crc_rx_step[15:8] = bus.data_i[8*j +: 8];
    end
  end

  assign bus.crc_err_o = r_crc_err;
`endif

  always_comb begin
    w_state    = r_state;
    w_rem      = r_rem;
    w_pay_left = r_pay_left;
    w_sop_pend = r_sop_pend;
    w_gap      = r_gap;
    w_hold     = r_hold;
    w_out      = '0;
    w_out.vc   = r_out.vc;
    w_out.dt   = r_out.dt;
    w_out.wc   = r_out.wc;
    w_out.data = r_out.data;
`ifdef CSI2_CRC_CHECK_EN
    w_crc      = r_crc;
    w_crc_rx   = r_crc_rx;
    w_crc_err  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.valid_i) begin
          w_hold = '0;
          if (w_ecc_err) begin
            w_out.ecc_err = 1'b1;
            w_out.phy_rst = 1'b1;
            w_state       = StHoldoff;
          end else begin
            w_out.hdr_valid = 1'b1;
            w_out.vc        = w_hdr.vc;
            w_out.dt        = w_hdr.dt;
            w_out.wc        = w_hdr.wc;
            w_out.ecc_corr  = w_ecc_corr;
            if (w_hdr.dt <= SHORT_DT_MAX) begin
              w_out.phy_rst = 1'b1;
              w_state       = StHoldoff;
            end else begin
              w_rem      = {1'b0, w_hdr.wc} + 17'd2;
              w_pay_left = w_hdr.wc;
              w_sop_pend = 1'b1;
              w_gap      = '0;
`ifdef CSI2_CRC_CHECK_EN
              w_crc      = CRC16_SEED;
`endif
              w_state    = StPayload;
            end
          end
        end
      end
      StPayload: begin
        if (bus.valid_i) begin
          w_gap      = '0;
          w_rem      = w_rem_nxt;
          w_pay_left = w_pay_nxt;
          if (w_npay != 3'd0) begin
            w_out.valid = 1'b1;
            w_out.be    = w_be;
            w_out.data  = bus.data_i & {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
            w_out.sop   = r_sop_pend;
            w_out.eop   = (w_pay_nxt == 16'd0);
            w_sop_pend  = 1'b0;
          end
`ifdef CSI2_CRC_CHECK_EN
          w_crc    = w_crc_step;
          w_crc_rx = w_crc_rx_step;
`endif
          if (w_rem_nxt == 17'd0) begin
            w_out.phy_rst = 1'b1;
            w_hold        = '0;
            w_state       = StHoldoff;
`ifdef CSI2_CRC_CHECK_EN
            w_crc_err     = (w_crc_step != w_crc_rx_step);
`endif
          end
        end else if (r_gap == GapLast) begin
          w_out.trunc_err = 1'b1;
          w_out.phy_rst   = 1'b1;
          w_hold          = '0;
          w_state         = StHoldoff;
        end else begin
          w_gap = r_gap + 1'b1;
        end
      end
      StHoldoff: begin
        if (r_hold == HoldLast) w_state = StIdle;
        else                    w_hold  = r_hold + 1'b1;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_rem      <= '0;
      r_pay_left <= '0;
      r_sop_pend <= 1'b0;
      r_gap      <= '0;
      r_hold     <= '0;
      r_out      <= '0;
`ifdef CSI2_CRC_CHECK_EN
      r_crc      <= CRC16_SEED;
      r_crc_rx   <= '0;
      r_crc_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state;
      r_rem      <= w_rem;
      r_pay_left <= w_pay_left;
      r_sop_pend <= w_sop_pend;
      r_gap      <= w_gap;
      r_hold     <= w_hold;
      r_out      <= w_out;
`ifdef CSI2_CRC_CHECK_EN
      r_crc      <= w_crc;
      r_crc_rx   <= w_crc_rx;
      r_crc_err  <= w_crc_err;
`endif
    end
  end

  assign bus.hdr_valid_o = r_out.hdr_valid;
  assign bus.hdr_vc_o    = r_out.vc;
  assign bus.hdr_dt_o    = r_out.dt;
  assign bus.hdr_wc_o    = r_out.wc;
  assign bus.pkt_data_o  = r_out.data;
  assign bus.pkt_be_o    = r_out.be;
  assign bus.pkt_valid_o = r_out.valid;
  assign bus.pkt_sop_o   = r_out.sop;
  assign bus.pkt_eop_o   = r_out.eop;
  assign bus.ecc_corr_o  = r_out.ecc_corr;
  assign bus.ecc_err_o   = r_out.ecc_err;
  assign bus.trunc_err_o = r_out.trunc_err;
  assign bus.phy_rst_o   = r_out.phy_rst;

endmodule
